// File: rtl/driver_param_stage_pkg.sv
// Shared definitions for the driver parameter staging block: register map,
// control/command bit positions, FSM encoding and default current code.
package driver_param_stage_pkg;

  localparam logic [2:0] ADDR_PW_LO  = 3'd0;
  localparam logic [2:0] ADDR_PW_HI  = 3'd1;
  localparam logic [2:0] ADDR_PER_LO = 3'd2;
  localparam logic [2:0] ADDR_PER_HI = 3'd3;
  localparam logic [2:0] ADDR_CUR    = 3'd4;
  localparam logic [2:0] ADDR_LIM    = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_CMD    = 3'd7;

  localparam int CTRL_TEST_MODE_BIT = 0;
  localparam int CTRL_PWM_CW_BIT    = 1;
  localparam int CMD_COMMIT_BIT     = 0;
  localparam int CMD_CLR_ERR_BIT    = 1;

  localparam logic [15:0] DEFAULT_CURRENT = 16'h3600;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VALIDATE  = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_APPLY     = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_HOLD      = 3'd5
  } state_e;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/driver_param_stage_param_clamp.sv
// Combinational clamp: limit is capped at the absolute maximum, current at the
// capped limit; flags whenever either value was reduced.
module param_clamp
  import driver_param_stage_pkg::*;
#(
  parameter logic [15:0] ABS_MAX = 16'h5FFF
) (
  input  logic [15:0] cur_i,
  input  logic [15:0] lim_i,
  output logic [15:0] cur_o,
  output logic [15:0] lim_o,
  output logic        clamped_o
);

  assign lim_o     = min16(lim_i, ABS_MAX);
  assign cur_o     = min16(cur_i, lim_o);
  assign clamped_o = (lim_o != lim_i) || (cur_o != cur_i);

endmodule

// File: rtl/driver_param_stage.sv
// Host parameter staging for driver_control: shadow registers, validated commit,
// atomic apply between pulse periods and a one-cycle DAC update strobe.
module driver_param_stage
  import driver_param_stage_pkg::*;
#(
  parameter logic [15:0] ABS_MAX_CURRENT = 16'h5FFF,
  parameter logic [23:0] MIN_PW          = 24'd2,
  parameter logic [23:0] PW_DEFAULT      = 24'd250,
  parameter logic [23:0] PER_DEFAULT     = 24'd2500,
  parameter logic [7:0]  DAC_GAP         = 8'd64,
  parameter logic [23:0] TIMEOUT         = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        commit,
  input  logic        period_active,
  output logic [23:0] pulse_width,
  output logic [23:0] period,
  output logic [15:0] drive_current,
  output logic [15:0] drive_current_limit,
  output logic        drive_current_update,
  output logic        test_mode,
  output logic        pwm_cw_mode_select,
  output logic        busy,
  output logic        err_invalid,
  output logic        err_timeout,
  output logic        clamped
);

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;

  logic [23:0] pw_sh_q, pw_sh_d, per_sh_q, per_sh_d;
  logic [15:0] cur_sh_q, cur_sh_d, lim_sh_q, lim_sh_d;
  logic [1:0]  ctrl_sh_q, ctrl_sh_d;

  logic [23:0] pw_snap_q, pw_snap_d, per_snap_q, per_snap_d;
  logic [15:0] cur_snap_q, cur_snap_d, lim_snap_q, lim_snap_d;
  logic [1:0]  ctrl_snap_q, ctrl_snap_d;

  logic [23:0] pw_act_q, pw_act_d, per_act_q, per_act_d;
  logic [15:0] cur_act_q, cur_act_d, lim_act_q, lim_act_d;
  logic [1:0]  ctrl_act_q, ctrl_act_d;

  logic        err_inv_q, err_inv_d, err_to_q, err_to_d, clamped_q, clamped_d;

  logic        cmd_wr, commit_req, clr_err;
  logic [15:0] cur_clamped, lim_clamped;
  logic        clamp_hit;

  assign cmd_wr     = wr_en && (wr_addr == ADDR_CMD);
  assign commit_req = commit || (cmd_wr && wr_data[CMD_COMMIT_BIT]);
  assign clr_err    = cmd_wr && wr_data[CMD_CLR_ERR_BIT];

  param_clamp #(.ABS_MAX(ABS_MAX_CURRENT)) u_clamp (
    .cur_i     (cur_snap_q),
    .lim_i     (lim_snap_q),
    .cur_o     (cur_clamped),
    .lim_o     (lim_clamped),
    .clamped_o (clamp_hit)
  );

  always_comb begin
    pw_sh_d   = pw_sh_q;
    per_sh_d  = per_sh_q;
    cur_sh_d  = cur_sh_q;
    lim_sh_d  = lim_sh_q;
    ctrl_sh_d = ctrl_sh_q;
    if (wr_en) begin
      case (wr_addr)
        ADDR_PW_LO:  pw_sh_d[15:0]   = wr_data;
        ADDR_PW_HI:  pw_sh_d[23:16]  = wr_data[7:0];
        ADDR_PER_LO: per_sh_d[15:0]  = wr_data;
        ADDR_PER_HI: per_sh_d[23:16] = wr_data[7:0];
        ADDR_CUR:    cur_sh_d        = wr_data;
        ADDR_LIM:    lim_sh_d        = wr_data;
        ADDR_CTRL:   ctrl_sh_d       = wr_data[1:0];
        default:     ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    pw_snap_d   = pw_snap_q;
    per_snap_d  = per_snap_q;
    cur_snap_d  = cur_snap_q;
    lim_snap_d  = lim_snap_q;
    ctrl_snap_d = ctrl_snap_q;
    pw_act_d    = pw_act_q;
    per_act_d   = per_act_q;
    cur_act_d   = cur_act_q;
    lim_act_d   = lim_act_q;
    ctrl_act_d  = ctrl_act_q;
    // Clear first so that a same-cycle set event below takes priority.
    err_inv_d   = clr_err ? 1'b0 : err_inv_q;
    err_to_d    = clr_err ? 1'b0 : err_to_q;
    clamped_d   = clr_err ? 1'b0 : clamped_q;

    if (commit_req && (state_q != ST_IDLE)) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (commit_req || pending_q) begin
          // Snapshot the next-state shadows so a same-cycle write is included.
          pw_snap_d   = pw_sh_d;
          per_snap_d  = per_sh_d;
          cur_snap_d  = cur_sh_d;
          lim_snap_d  = lim_sh_d;
          ctrl_snap_d = ctrl_sh_d;
          pending_d   = 1'b0;
          state_d     = ST_VALIDATE;
        end
      end
      ST_VALIDATE: begin
        if ((pw_snap_q < MIN_PW) ||
            ({1'b0, per_snap_q} < ({1'b0, pw_snap_q} + 25'd2))) begin
          err_inv_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          err_inv_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!period_active) begin
          state_d = ST_APPLY;
        end else if (cnt_q == (TIMEOUT - 24'd1)) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_APPLY: begin
        pw_act_d   = pw_snap_q;
        per_act_d  = per_snap_q;
        cur_act_d  = cur_clamped;
        lim_act_d  = lim_clamped;
        ctrl_act_d = ctrl_snap_q;
        if (clamp_hit) clamped_d = 1'b1;
        state_d    = ST_UPDATE;
      end
      ST_UPDATE: begin
        cnt_d   = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == {16'd0, DAC_GAP - 8'd1}) state_d = ST_IDLE;
        else                                  cnt_d   = cnt_q + 24'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      pw_sh_q     <= PW_DEFAULT;
      per_sh_q    <= PER_DEFAULT;
      cur_sh_q    <= DEFAULT_CURRENT;
      lim_sh_q    <= ABS_MAX_CURRENT;
      ctrl_sh_q   <= 2'b00;
      pw_snap_q   <= PW_DEFAULT;
      per_snap_q  <= PER_DEFAULT;
      cur_snap_q  <= DEFAULT_CURRENT;
      lim_snap_q  <= ABS_MAX_CURRENT;
      ctrl_snap_q <= 2'b00;
      pw_act_q    <= PW_DEFAULT;
      per_act_q   <= PER_DEFAULT;
      cur_act_q   <= DEFAULT_CURRENT;
      lim_act_q   <= ABS_MAX_CURRENT;
      ctrl_act_q  <= 2'b00;
      err_inv_q   <= 1'b0;
      err_to_q    <= 1'b0;
      clamped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      pw_sh_q     <= pw_sh_d;
      per_sh_q    <= per_sh_d;
      cur_sh_q    <= cur_sh_d;
      lim_sh_q    <= lim_sh_d;
      ctrl_sh_q   <= ctrl_sh_d;
      pw_snap_q   <= pw_snap_d;
      per_snap_q  <= per_snap_d;
      cur_snap_q  <= cur_snap_d;
      lim_snap_q  <= lim_snap_d;
      ctrl_snap_q <= ctrl_snap_d;
      pw_act_q    <= pw_act_d;
      per_act_q   <= per_act_d;
      cur_act_q   <= cur_act_d;
      lim_act_q   <= lim_act_d;
      ctrl_act_q  <= ctrl_act_d;
      err_inv_q   <= err_inv_d;
      err_to_q    <= err_to_d;
      clamped_q   <= clamped_d;
    end
  end

  assign pulse_width          = pw_act_q;
  assign period               = per_act_q;
  assign drive_current        = cur_act_q;
  assign drive_current_limit  = lim_act_q;
  assign test_mode            = ctrl_act_q[CTRL_TEST_MODE_BIT];
  assign pwm_cw_mode_select   = ctrl_act_q[CTRL_PWM_CW_BIT];
  assign drive_current_update = (state_q == ST_UPDATE);
  assign busy                 = (state_q != ST_IDLE);
  assign err_invalid          = err_inv_q;
  assign err_timeout          = err_to_q;
  assign clamped              = clamped_q;

endmodule

// File: tb/tb_driver_param_stage.sv
// Directed bench for driver_param_stage: expected active sets are queued at commit
// time and checked against the DUT outputs on every update strobe.
module tb_driver_param_stage;

  typedef struct packed {
    logic [23:0] pw;
    logic [23:0] per;
    logic [15:0] cur;
    logic [15:0] lim;
    logic [1:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        period_active = 1'b0;
  logic [23:0] pulse_width, period;
  logic [15:0] drive_current, drive_current_limit;
  logic        drive_current_update, test_mode, pwm_cw_mode_select;
  logic        busy, err_invalid, err_timeout, clamped;

  // Second instance with a short timeout, used only for the timeout case.
  logic        t_commit = 1'b0;
  logic        t_period_active = 1'b0;
  logic        t_wr_en = 1'b0;
  logic [2:0]  t_wr_addr = '0;
  logic [15:0] t_wr_data = '0;
  logic [23:0] t_pulse_width, t_period;
  logic [15:0] t_drive_current, t_drive_current_limit;
  logic        t_update, t_test_mode, t_pwm, t_busy, t_err_invalid, t_err_timeout, t_clamped;

  int   n_assert = 0;
  int   n_fail = 0;
  int   strobes = 0;
  int   t_strobes = 0;
  exp_t exp_q[$];

  always #20 clk = ~clk;

  driver_param_stage dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .period_active(period_active),
    .pulse_width(pulse_width), .period(period), .drive_current(drive_current),
    .drive_current_limit(drive_current_limit), .drive_current_update(drive_current_update),
    .test_mode(test_mode), .pwm_cw_mode_select(pwm_cw_mode_select), .busy(busy),
    .err_invalid(err_invalid), .err_timeout(err_timeout), .clamped(clamped)
  );

  driver_param_stage #(.TIMEOUT(24'd16)) dut_t (
    .clk(clk), .rstn(rstn), .wr_en(t_wr_en), .wr_addr(t_wr_addr), .wr_data(t_wr_data),
    .commit(t_commit), .period_active(t_period_active),
    .pulse_width(t_pulse_width), .period(t_period), .drive_current(t_drive_current),
    .drive_current_limit(t_drive_current_limit), .drive_current_update(t_update),
    .test_mode(t_test_mode), .pwm_cw_mode_select(t_pwm), .busy(t_busy),
    .err_invalid(t_err_invalid), .err_timeout(t_err_timeout), .clamped(t_clamped)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic push(input int pw, input int per, input int cur, input int lim, input int ctrl);
    exp_t e;
    e.pw = 24'(pw); e.per = 24'(per); e.cur = 16'(cur); e.lim = 16'(lim); e.ctrl = 2'(ctrl);
    exp_q.push_back(e);
  endtask

  // Commits and tracks the busy window; lat is the cycle index of the strobe (-1 if none).
  task automatic do_commit(input int max_cyc, output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    pulse_commit();
    for (int i = 1; i <= max_cyc; i++) begin
      if (drive_current_update && lat < 0) lat = i;
      if (!busy) break;
      busy_n++;
      tick();
    end
    chk("commit_done", busy, 0);
  endtask

  task automatic wait_update(input int max_cyc, output int n);
    n = 0;
    while (!drive_current_update && n < max_cyc) begin
      tick();
      n++;
    end
    chk("update_seen", drive_current_update, 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk("busy_clear", busy, 0);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rstn && drive_current_update) begin
      strobes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pw", pulse_width, e.pw);
        chk("sb_per", period, e.per);
        chk("sb_cur", drive_current, e.cur);
        chk("sb_lim", drive_current_limit, e.lim);
        chk("sb_ctrl", {pwm_cw_mode_select, test_mode}, e.ctrl);
        $display("update: pw=%0d per=%0d cur=%h lim=%h ctrl=%b", pulse_width, period,
                 drive_current, drive_current_limit, {pwm_cw_mode_select, test_mode});
      end
    end
    if (rstn && t_update) t_strobes++;
  end

  initial begin
    int lat, busy_n, n, s0;

    // Reset state
    repeat (3) tick();
    chk("rst_pw", pulse_width, 250);
    chk("rst_per", period, 2500);
    chk("rst_cur", drive_current, 16'h3600);
    chk("rst_lim", drive_current_limit, 16'h5FFF);
    chk("rst_flags", {drive_current_update, test_mode, pwm_cw_mode_select, busy,
                      err_invalid, err_timeout, clamped}, 0);
    rstn = 1'b1;
    tick();

    // 1: basic commit, latency and busy window
    wr(0, 100); wr(1, 0); wr(2, 1000); wr(3, 0); wr(4, 16'h2000); wr(5, 16'h4000);
    chk("shadow_no_touch", pulse_width, 250);
    push(100, 1000, 16'h2000, 16'h4000, 0);
    do_commit(200, lat, busy_n);
    chk("t1_latency", lat, 4);
    chk("t1_busy_cycles", busy_n, 68);
    chk("t1_clamped", clamped, 0);

    // 2: validation reject at pw+1, accept at pw+2, reject below MIN_PW
    wr(0, 500); wr(2, 501);
    s0 = strobes;
    do_commit(20, lat, busy_n);
    chk("t2_reject_strobe", strobes - s0, 0);
    chk("t2_err_invalid", err_invalid, 1);
    chk("t2_pw_kept", pulse_width, 100);
    wr(2, 502);
    push(500, 502, 16'h2000, 16'h4000, 0);
    do_commit(200, lat, busy_n);
    chk("t2_accept_lat", lat, 4);
    chk("t2_err_cleared", err_invalid, 0);
    wr(0, 1); wr(2, 100);
    s0 = strobes;
    do_commit(20, lat, busy_n);
    chk("t2_minpw_reject", {err_invalid, 8'(strobes - s0)}, {1'b1, 8'd0});
    wr(0, 500); wr(2, 502);

    // 3: clamping of current and limit, ctrl bits, then clear flags
    wr(4, 16'h7000); wr(5, 16'h8000); wr(6, 16'h0001);
    push(500, 502, 16'h5FFF, 16'h5FFF, 1);
    do_commit(200, lat, busy_n);
    chk("t3_clamped", clamped, 1);
    chk("t3_err_invalid", err_invalid, 0);
    wr(7, 16'h0002);
    chk("t3_clr_err", {clamped, err_invalid, err_timeout}, 0);

    // 4: wait while a period is active, apply in the cycle after release
    wr(0, 2); wr(2, 4); wr(4, 16'h1000); wr(5, 16'h2000); wr(6, 16'h0002);
    push(2, 4, 16'h1000, 16'h2000, 2);
    period_active = 1'b1;
    s0 = strobes;
    pulse_commit();
    repeat (300) tick();
    chk("t4_held_busy", busy, 1);
    chk("t4_held_no_strobe", strobes - s0, 0);
    chk("t4_held_pw", pulse_width, 500);
    period_active = 1'b0;
    wait_update(10, n);
    chk("t4_release_lat", n, 2);
    wait_idle(200);

    // 4b: timeout instance with period_active stuck high
    t_period_active = 1'b1;
    t_commit = 1'b1;
    tick();
    t_commit = 1'b0;
    repeat (40) tick();
    chk("t4_timeout_err", t_err_timeout, 1);
    chk("t4_timeout_idle", t_busy, 0);
    chk("t4_timeout_no_strobe", t_strobes, 0);
    chk("t4_timeout_pw", t_pulse_width, 250);

    // 5: two commits during HOLD merge into one extra update with the new shadow
    push(2, 4, 16'h1000, 16'h2000, 2);
    s0 = strobes;
    pulse_commit();
    wait_update(10, n);
    push(2, 4, 16'h0123, 16'h2000, 2);
    tick();
    pulse_commit();
    wr(4, 16'h0123);
    wr(7, 16'h0001);
    wait_update(200, n);
    wait_idle(200);
    repeat (20) tick();
    chk("t5_two_strobes", strobes - s0, 2);
    chk("t5_idle", busy, 0);
    chk("t5_cur", drive_current, 16'h0123);

    // 6: reset during WAIT_IDLE restores defaults and drops the commit
    period_active = 1'b1;
    wr(0, 300); wr(2, 3000);
    pulse_commit();
    repeat (4) tick();
    chk("t6_busy_before", busy, 1);
    rstn = 1'b0;
    tick();
    chk("t6_rst_pw", pulse_width, 250);
    chk("t6_rst_per", period, 2500);
    chk("t6_rst_cur", drive_current, 16'h3600);
    chk("t6_rst_busy", busy, 0);
    rstn = 1'b1;
    period_active = 1'b0;
    s0 = strobes;
    repeat (100) tick();
    chk("t6_no_strobe", strobes - s0, 0);
    chk("t6_idle", busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
